// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// one operand bit per clock, LSB first, start/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_sub;
    logic             r_carry;
    logic             r_ovf;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_msb;

    always_comb begin
        w_s    = r_x[0] ^ r_y[0] ^ r_c;
        w_cout = (r_x[0] & r_y[0]) | (r_x[0] & r_c) | (r_y[0] & r_c);
        w_last = (r_cnt == CW'(WIDTH - 1));
        // sum bit enters at the MSB; works for WIDTH=1 too
        w_msb            = '0;
        w_msb[WIDTH-1]   = w_s;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x     <= i_x;
                        r_y     <= i_sub ? ~i_y : i_y;
                        r_c     <= i_carry ^ i_sub;
                        r_cnt   <= '0;
                        r_sub   <= i_sub;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x   <= r_x >> 1;
                    r_y   <= r_y >> 1;
                    r_sum <= (r_sum >> 1) | w_msb;
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // old c is the carry into the MSB
                        r_carry <= r_sub ? ~w_cout : w_cout;
                        r_ovf   <= r_c ^ w_cout;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_sum      = r_sum;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;

endmodule
